// File: rtl/shift_detect_sched_pkg.sv
// ---------------------------------------------------------------------------
// shift_detect_sched_pkg
// Shared constants for the shift-window detector scheduler:
//   - arbiter FSM state encodings (IDLE / CLEAR / SERVE / RELEASE)
//   - hit counter saturation value and a saturating increment helper
// ---------------------------------------------------------------------------
package shift_detect_sched_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CLEAR   = 2'd1;
   localparam logic [1:0] ST_SERVE   = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   localparam logic [7:0] HIT_COUNT_MAX = 8'hFF;

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == HIT_COUNT_MAX) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/shift_detect_sched_window.sv
// ---------------------------------------------------------------------------
// shift_window
// DEPTH-bit serial shift register with fill counter.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   clear             synchronous clear of window and fill
//   shift, shift_bit  shift enable and serial bit (enters at bit 0)
//   window            register contents, bit 0 newest
//   full              fill would be DEPTH after a shift this cycle
//   all_one/all_zero  shifted window would be all ones / all zeros
// The flags describe the post-shift window so the owner can register a
// match pulse on the same edge that accepts the bit.
// ---------------------------------------------------------------------------
module shift_window
   import shift_detect_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             shift,
   input  logic             shift_bit,
   output logic [DEPTH-1:0] window,
   output logic             full,
   output logic             all_one,
   output logic             all_zero
);

   localparam int unsigned FW = $clog2(DEPTH + 1);

   logic [FW-1:0]    fill;
   logic [FW-1:0]    fill_next;
   logic [DEPTH-1:0] shifted;

   always_comb begin
      shifted   = {window[DEPTH-2:0], shift_bit};
      fill_next = (fill == FW'(DEPTH)) ? fill : fill + 1'b1;
      full      = (fill_next == FW'(DEPTH));
      all_one   = &shifted;
      all_zero  = ~|shifted;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         window <= '0;
         fill   <= '0;
      end else if (clear) begin
         window <= '0;
         fill   <= '0;
      end else if (shift) begin
         window <= shifted;
         fill   <= fill_next;
      end
   end

endmodule

// File: rtl/shift_detect_sched.sv
// ---------------------------------------------------------------------------
// shift_detect_sched
// Round-robin scheduler sharing one serial window detector between two
// serial bit requesters. Each grant starts from a cleared window; matches
// (all ones / all zeros once the window is full) are pulsed, tagged with
// the owner and counted in a saturating hit counter.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   req[1:0]          per-requester level request
//   bit_valid[1:0]    per-requester bit strobe (owner only, in SERVE)
//   bit_in[1:0]       per-requester serial bit
//   last[1:0]         per-requester end-of-stream, qualified by bit_valid
//   grant[1:0]        one-hot owner, zero outside SERVE
//   busy              high in CLEAR, SERVE, RELEASE
//   window            detector contents, bit 0 newest
//   hit_one/hit_zero  one-cycle match pulses
//   hit_id            owner of the latest hit
//   hit_count         saturating number of hits since reset
// ---------------------------------------------------------------------------
module shift_detect_sched
   import shift_detect_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned BURST = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [1:0]       bit_valid,
   input  logic [1:0]       bit_in,
   input  logic [1:0]       last,
   output logic [1:0]       grant,
   output logic             busy,
   output logic [DEPTH-1:0] window,
   output logic             hit_one,
   output logic             hit_zero,
   output logic             hit_id,
   output logic [7:0]       hit_count
);

   logic [1:0] state;
   logic       owner;
   logic       prio;
   logic [7:0] run_cnt;

   logic accept;
   logic burst_done;
   logic release_now;
   logic win_clear;
   logic win_full;
   logic win_all_one;
   logic win_all_zero;
   logic match;

   // Bits are accepted only once the registered grant is visible, so the
   // first SERVE cycle (grant still low) never shifts.
   always_comb begin
      accept      = (state == ST_SERVE) && grant[owner] && bit_valid[owner] && req[owner];
      burst_done  = ((run_cnt + 8'd1) == 8'(BURST));
      release_now = (state == ST_SERVE) &&
                    (!req[owner] || (accept && (last[owner] || burst_done)));
      win_clear   = (state == ST_CLEAR);
      match       = accept && win_full && (win_all_one || win_all_zero);
      busy        = (state != ST_IDLE);
   end

   shift_window #(
      .DEPTH (DEPTH)
   ) u_window (
      .clock     (clock),
      .reset     (reset),
      .clear     (win_clear),
      .shift     (accept),
      .shift_bit (bit_in[owner]),
      .window    (window),
      .full      (win_full),
      .all_one   (win_all_one),
      .all_zero  (win_all_zero)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         owner   <= 1'b0;
         prio    <= 1'b0;
         run_cnt <= '0;
         grant   <= '0;
      end else begin
         grant <= ((state == ST_SERVE) && !release_now) ?
                  (owner ? 2'b10 : 2'b01) : 2'b00;
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  owner <= (req == 2'b11) ? prio : req[1];
                  state <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               run_cnt <= '0;
               state   <= ST_SERVE;
            end
            ST_SERVE: begin
               if (accept)
                  run_cnt <= run_cnt + 8'd1;
               if (release_now)
                  state <= ST_RELEASE;
            end
            default: begin
               prio  <= ~owner;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hit_one   <= 1'b0;
         hit_zero  <= 1'b0;
         hit_id    <= 1'b0;
         hit_count <= '0;
      end else begin
         hit_one  <= accept && win_full && win_all_one;
         hit_zero <= accept && win_full && win_all_zero;
         if (match) begin
            hit_id    <= owner;
            hit_count <= sat_inc(hit_count);
         end
      end
   end

endmodule

// File: tb/tb_shift_detect_sched.sv
// ---------------------------------------------------------------------------
// tb_shift_detect_sched
// Directed self-checking bench for shift_detect_sched (DEPTH=4, BURST=8).
// ---------------------------------------------------------------------------
module tb_shift_detect_sched;

   logic       clock;
   logic       reset;
   logic [1:0] req;
   logic [1:0] bit_valid;
   logic [1:0] bit_in;
   logic [1:0] last;
   logic [1:0] grant;
   logic       busy;
   logic [3:0] window;
   logic       hit_one;
   logic       hit_zero;
   logic       hit_id;
   logic [7:0] hit_count;

   int total = 0;
   int bad   = 0;

   shift_detect_sched #(
      .DEPTH (4),
      .BURST (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .last      (last),
      .grant     (grant),
      .busy      (busy),
      .window    (window),
      .hit_one   (hit_one),
      .hit_zero  (hit_zero),
      .hit_id    (hit_id),
      .hit_count (hit_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Request as requester idx, wait (bounded) for its grant, stream n bits
   // of value val, optionally flag last on the final bit, then drop request.
   task automatic run_grant(input int idx, input int n, input bit use_last, input bit val);
      logic [1:0] exp_grant;
      exp_grant = (idx == 1) ? 2'b10 : 2'b01;
      req[idx] = 1'b1;
      for (int c = 0; c < 8 && grant !== exp_grant; c++) tick();
      chk("grant_wait", 32'(grant), 32'(exp_grant));
      for (int i = 0; i < n; i++) begin
         bit_valid[idx] = 1'b1;
         bit_in[idx]    = val;
         last[idx]      = use_last && (i == n - 1);
         tick();
      end
      bit_valid = '0;
      last      = '0;
      req       = '0;
      tick();
      tick();
   endtask

   initial begin
      logic [9:0] pat;
      logic [5:0] hz_exp;
      logic [7:0] hc_exp [6];

      reset     = 1'b0;
      req       = '0;
      bit_valid = '0;
      bit_in    = '0;
      last      = '0;
      tick();
      tick();

      // Reset state
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_window", 32'(window), 32'h0);
      chk("rst_hit_one", 32'(hit_one), 32'h0);
      chk("rst_hit_zero", 32'(hit_zero), 32'h0);
      chk("rst_hit_id", 32'(hit_id), 32'h0);
      chk("rst_hit_count", 32'(hit_count), 32'h0);

      reset = 1'b1;
      tick();

      // Only requester 1: grant latency and a single all-ones hit
      req = 2'b10;
      tick();
      chk("a_clear_busy", 32'(busy), 32'h1);
      chk("a_clear_grant", 32'(grant), 32'h0);
      tick();
      chk("a_k1_grant", 32'(grant), 32'h0);
      tick();
      chk("a_k2_grant", 32'(grant), 32'h2);
      for (int i = 0; i < 4; i++) begin
         bit_valid = 2'b11;           // non-owner strobe must be ignored
         bit_in    = 2'b10;
         last      = (i == 3) ? 2'b10 : 2'b00;
         tick();
         if (i == 2) begin
            chk("a_win3", 32'(window), 32'h7);
            chk("a_nohit3", 32'(hit_one), 32'h0);
         end
      end
      chk("a_hit_one", 32'(hit_one), 32'h1);
      chk("a_hit_id", 32'(hit_id), 32'h1);
      chk("a_hit_count", 32'(hit_count), 32'h1);
      chk("a_window", 32'(window), 32'hF);
      chk("a_rel_grant", 32'(grant), 32'h0);
      chk("a_rel_busy", 32'(busy), 32'h1);
      bit_valid = '0;
      last      = '0;
      req       = '0;
      tick();
      chk("a_pulse_end", 32'(hit_one), 32'h0);
      chk("a_idle_busy", 32'(busy), 32'h0);
      chk("a_win_hold", 32'(window), 32'hF);

      // Both request: owner 0 first, then owner 1 after round-robin
      req = 2'b11;
      tick();
      tick();
      tick();
      chk("b_grant0", 32'(grant), 32'h1);
      pat = 10'b0000000101;           // bits 1,0,1 in order (LSB first)
      for (int i = 0; i < 3; i++) begin
         bit_valid = 2'b01;
         bit_in    = {1'b0, pat[i]};
         last      = (i == 2) ? 2'b01 : 2'b00;
         tick();
      end
      chk("b_win0", 32'(window), 32'h5);
      chk("b_rel_grant", 32'(grant), 32'h0);
      chk("b_no_hit", 32'({hit_one, hit_zero}), 32'h0);
      bit_valid = '0;
      last      = '0;
      tick();
      chk("b_idle_grant", 32'(grant), 32'h0);
      tick();
      chk("b_clear_grant", 32'(grant), 32'h0);
      tick();
      chk("b_serve_grant", 32'(grant), 32'h0);
      tick();
      chk("b_grant1", 32'(grant), 32'h2);

      // Burst limit: 10 bits offered, 8 accepted
      req = 2'b10;
      pat = 10'b1101001101;           // bits 1,0,1,1,0,0,1,0,1,1
      for (int i = 0; i < 10; i++) begin
         bit_valid = 2'b10;
         bit_in    = {pat[i], 1'b0};
         tick();
         if (i == 6) chk("c_grant_b7", 32'(grant), 32'h2);
         if (i == 7) begin
            chk("c_grant_b8", 32'(grant), 32'h0);
            chk("c_win_b8", 32'(window), 32'h2);
         end
         if (i == 8) chk("c_win_b9", 32'(window), 32'h2);
         if (i == 9) chk("c_win_b10", 32'(window), 32'h2);
      end
      bit_valid = '0;
      req       = '0;
      tick();
      chk("c_cleared", 32'(window), 32'h0);
      tick();
      tick();
      chk("c_idle_busy", 32'(busy), 32'h0);
      chk("c_count", 32'(hit_count), 32'h1);

      // Six zeros on owner 0: overlapping all-zero pulses on bits 4..6
      hz_exp = 6'b111000;
      hc_exp = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4};
      req = 2'b01;
      tick();
      tick();
      tick();
      chk("d_grant", 32'(grant), 32'h1);
      for (int i = 0; i < 6; i++) begin
         bit_valid = 2'b01;
         bit_in    = 2'b00;
         last      = (i == 5) ? 2'b01 : 2'b00;
         tick();
         chk($sformatf("d_hz_b%0d", i + 1), 32'(hit_zero), 32'(hz_exp[i]));
         chk($sformatf("d_hc_b%0d", i + 1), 32'(hit_count), 32'(hc_exp[i]));
      end
      chk("d_hit_id", 32'(hit_id), 32'h0);
      bit_valid = '0;
      last      = '0;
      req       = '0;
      tick();
      chk("d_pulse_end", 32'(hit_zero), 32'h0);
      tick();

      // Saturation: 50 burst grants of ones give 5 hits each
      for (int g = 0; g < 50; g++) run_grant(1, 8, 1'b0, 1'b1);
      chk("e_count_254", 32'(hit_count), 32'd254);
      run_grant(0, 4, 1'b1, 1'b1);
      chk("e_count_255", 32'(hit_count), 32'd255);
      chk("e_hit_id", 32'(hit_id), 32'h0);
      run_grant(1, 5, 1'b1, 1'b1);
      chk("e_count_sat", 32'(hit_count), 32'd255);
      chk("e_hit_id1", 32'(hit_id), 32'h1);

      // Asynchronous reset in the middle of a grant
      req = 2'b01;
      for (int c = 0; c < 8 && grant !== 2'b01; c++) tick();
      chk("f_grant", 32'(grant), 32'h1);
      bit_valid = 2'b01;
      bit_in    = 2'b01;
      tick();
      tick();
      chk("f_win2", 32'(window), 32'h3);
      bit_valid = '0;
      reset     = 1'b0;
      #1;
      chk("f_rst_grant", 32'(grant), 32'h0);
      chk("f_rst_window", 32'(window), 32'h0);
      chk("f_rst_count", 32'(hit_count), 32'h0);
      chk("f_rst_busy", 32'(busy), 32'h0);
      req   = '0;
      reset = 1'b1;
      tick();
      chk("f_idle_busy", 32'(busy), 32'h0);
      chk("f_idle_grant", 32'(grant), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
